// File: rtl/branch_predictor.sv
// Fetch-stage branch predictor: direct-mapped BTB of 2-bit
// saturating counters with tag, target and combinational lookup.
module branch_predictor #(
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush_in,
  input  logic [63:0] pc_in,
  output logic        predicted_taken_out,
  output logic [63:0] predicted_pc_out,
  output logic        hit_out,
  input  logic        update_valid_in,
  input  logic [63:0] update_pc_in,
  input  logic        update_taken_in,
  input  logic [63:0] update_target_in
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int IDX_HI  = INDEX_BITS + 1;
  localparam int TAG_LO  = INDEX_BITS + 2;
  localparam int TAG_HI  = INDEX_BITS + TAG_BITS + 1;

  logic                r_valid  [ENTRIES];
  logic [TAG_BITS-1:0] r_tag    [ENTRIES];
  logic [1:0]          r_ctr    [ENTRIES];
  logic [63:2]         r_target [ENTRIES];

  logic [INDEX_BITS-1:0] w_idx;
  logic [TAG_BITS-1:0]   w_tag;
  logic                  w_hit;
  logic                  w_taken;

  logic [INDEX_BITS-1:0] w_u_idx;
  logic [TAG_BITS-1:0]   w_u_tag;
  logic                  w_u_hit;
  logic [1:0]            w_u_ctr;
  logic [1:0]            w_u_ctr_nxt;

  // Low PC bits and untagged high bits never reach the table.
  logic w_unused;
  assign w_unused = ^{update_pc_in[63:TAG_HI+1],
                      update_pc_in[1:0],
                      update_target_in[1:0]};

  assign w_idx = pc_in[IDX_HI:2];
  assign w_tag = pc_in[TAG_HI:TAG_LO];

  // Lookup; reset masks the table so outputs are clean during reset.
  assign w_hit   = ~reset & r_valid[w_idx]
                 & (r_tag[w_idx] == w_tag);
  assign w_taken = w_hit & r_ctr[w_idx][1];

  assign hit_out             = w_hit;
  assign predicted_taken_out = w_taken;
  assign predicted_pc_out    = w_taken
                             ? {r_target[w_idx], 2'b00}
                             : pc_in + 64'd4;

  assign w_u_idx = update_pc_in[IDX_HI:2];
  assign w_u_tag = update_pc_in[TAG_HI:TAG_LO];
  assign w_u_hit = r_valid[w_u_idx]
                 & (r_tag[w_u_idx] == w_u_tag);
  assign w_u_ctr = r_ctr[w_u_idx];

  // Saturating counter step for the entry being trained.
  always_comb begin
    w_u_ctr_nxt = w_u_ctr;
    if (update_taken_in) begin
      if (w_u_ctr != 2'b11)
        w_u_ctr_nxt = w_u_ctr + 2'b01;
    end else begin
      if (w_u_ctr != 2'b00)
        w_u_ctr_nxt = w_u_ctr - 2'b01;
    end
  end

  // Table state: reset beats flush beats training.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_ctr[i]    <= 2'b01;
        r_target[i] <= '0;
      end
    end else if (flush_in) begin
      for (int i = 0; i < ENTRIES; i++)
        r_valid[i] <= 1'b0;
    end else if (update_valid_in) begin
      if (w_u_hit) begin
        r_ctr[w_u_idx] <= w_u_ctr_nxt;
        if (update_taken_in)
          r_target[w_u_idx] <= update_target_in[63:2];
      end else if (update_taken_in) begin
        r_valid[w_u_idx]  <= 1'b1;
        r_tag[w_u_idx]    <= w_u_tag;
        r_ctr[w_u_idx]    <= 2'b10;
        r_target[w_u_idx] <= update_target_in[63:2];
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: each step queues the
// expected lookup result, which is popped and checked mid-cycle.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush_in;
  logic [63:0] pc_in;
  logic        predicted_taken_out;
  logic [63:0] predicted_pc_out;
  logic        hit_out;
  logic        update_valid_in;
  logic [63:0] update_pc_in;
  logic        update_taken_in;
  logic [63:0] update_target_in;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic        hit;
    logic        tk;
    logic [63:0] pc;
  } exp_t;

  exp_t sb[$];

  branch_predictor #(
    .INDEX_BITS(6),
    .TAG_BITS(10)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .flush_in            (flush_in),
    .pc_in               (pc_in),
    .predicted_taken_out (predicted_taken_out),
    .predicted_pc_out    (predicted_pc_out),
    .hit_out             (hit_out),
    .update_valid_in     (update_valid_in),
    .update_pc_in        (update_pc_in),
    .update_taken_in     (update_taken_in),
    .update_target_in    (update_target_in)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs, queue expectation, compare at negedge.
  task automatic step(input logic rst, input logic fl,
                      input logic [63:0] pc,
                      input logic uv, input logic [63:0] upc,
                      input logic ut, input logic [63:0] utg,
                      input logic eh, input logic et,
                      input logic [63:0] epc,
                      input string tag);
    exp_t e;
    reset            = rst;
    flush_in         = fl;
    pc_in            = pc;
    update_valid_in  = uv;
    update_pc_in     = upc;
    update_taken_in  = ut;
    update_target_in = utg;
    e.tag = tag;
    e.hit = eh;
    e.tk  = et;
    e.pc  = epc;
    sb.push_back(e);
    @(negedge clk);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      check({e.tag, "_hit"}, {63'd0, hit_out}, {63'd0, e.hit});
      check({e.tag, "_tk"},
            {63'd0, predicted_taken_out}, {63'd0, e.tk});
      check({e.tag, "_pc"}, predicted_pc_out, e.pc);
    end
    @(posedge clk);
    #1;
  endtask

  localparam logic [63:0] A   = 64'h1000;
  localparam logic [63:0] B   = 64'h5000;
  localparam logic [63:0] C   = 64'h7000;
  localparam logic [63:0] T1  = 64'h2000;
  localparam logic [63:0] T2  = 64'h2400;
  localparam logic [63:0] Z   = 64'h0;
  localparam logic [63:0] TOP = 64'hFFFF_FFFF_FFFF_FFFC;

  initial begin
    reset = 1'b1;
    flush_in = 1'b0;
    pc_in = A;
    update_valid_in = 1'b0;
    update_pc_in = Z;
    update_taken_in = 1'b0;
    update_target_in = Z;
    @(posedge clk);
    #1;
    // reset asserted: outputs quiet
    step(1,0,A, 0,Z,0,Z, 0,0,A+4, "in_rst0");
    step(1,0,A, 0,Z,0,Z, 0,0,A+4, "in_rst1");
    step(0,0,A, 0,Z,0,Z, 0,0,A+4, "post_rst");
    // same-cycle read sees pre-update, then allocated
    step(0,0,A, 1,A,1,T1, 0,0,A+4, "rdw");
    step(0,0,A, 0,Z,0,Z, 1,1,T1, "alloc");
    step(0,0,A+64'h100, 0,Z,0,Z, 0,0,A+64'h104, "tagmis");
    // ctr 10 -> 11 -> 11 -> 11, target refreshed on last
    step(0,0,A, 1,A,1,T1, 1,1,T1, "tk1");
    step(0,0,A, 1,A,1,T1, 1,1,T1, "tk2");
    step(0,0,A, 1,A,1,T2, 1,1,T1, "tk3");
    // 11 -> 10 -> 01
    step(0,0,A, 1,A,0,Z, 1,1,T2, "nt1");
    step(0,0,A, 1,A,0,Z, 1,1,T2, "nt2");
    step(0,0,A, 0,Z,0,Z, 1,0,A+4, "ctr01");
    // 01 -> 00 -> 00, then 00 -> 01 -> 10
    step(0,0,A, 1,A,0,Z, 1,0,A+4, "nt3");
    step(0,0,A, 1,A,0,Z, 1,0,A+4, "nt4");
    step(0,0,A, 1,A,1,T2, 1,0,A+4, "tk4");
    step(0,0,A, 0,Z,0,Z, 1,0,A+4, "sat00");
    step(0,0,A, 1,A,1,T2, 1,0,A+4, "tk5");
    step(0,0,A, 0,Z,0,Z, 1,1,T2, "retaken");
    // flush wins over a coincident update
    step(0,1,A, 1,B,1,64'h6000, 1,1,T2, "flush");
    step(0,0,A, 0,Z,0,Z, 0,0,A+4, "flush_a");
    step(0,0,B, 0,Z,0,Z, 0,0,B+4, "flush_b");
    // retrain: allocation restarts at 10
    step(0,0,A, 1,A,1,T1, 0,0,A+4, "realloc");
    step(0,0,A, 1,A,0,Z, 1,1,T1, "re_tk");
    step(0,0,A, 0,Z,0,Z, 1,0,A+4, "re_ctr10");
    // wrap-around of pc+4
    step(0,0,TOP, 0,Z,0,Z, 0,0,Z, "wrap");
    // miss + not-taken leaves no entry
    step(0,0,C, 1,C,0,Z, 0,0,C+4, "missnt");
    step(0,0,C, 0,Z,0,Z, 0,0,C+4, "missnt_chk");
    // low PC bits ignored, target low bits masked
    step(0,0,C, 1,C+2,1,64'h3002, 0,0,C+4, "align_upd");
    step(0,0,C+1, 0,Z,0,Z, 1,1,64'h3000, "align");
    // reset mid-training drops history and the update
    step(1,0,C, 1,C,1,T1, 0,0,C+4, "rst_mid");
    step(0,0,C, 0,Z,0,Z, 0,0,C+4, "rst_clr");
    step(0,0,C, 1,C,0,Z, 0,0,C+4, "rst_nt");
    step(0,0,C, 0,Z,0,Z, 0,0,C+4, "rst_miss");
    if (sb.size() != 0)
      check("sb_left", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Fetch-stage branch predictor with a direct-mapped branch target buffer (BTB) of 2-bit saturating counters. Each cycle it predicts direction and target for the fetch PC. The branch unit's resolved outcome arrives one cycle later on the update port and trains the BTB. It supplies the `predicted_taken` value that the execute-stage branch unit compares against, and learns from the resolution that unit produces.

## Interface
- `INDEX_BITS`, 6: log2 of entry count (64 entries); index = `pc[INDEX_BITS+1:2]`.
- `TAG_BITS`, 10: partial tag width; tag = `pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2]`.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `flush_in`  in  1  invalidate all entries next edge (context switch / fence.i).
- `pc_in`  in  64  fetch PC to predict.
- `predicted_taken_out`  out  1  predict taken.
- `predicted_pc_out`  out  64  next fetch PC.
- `hit_out`  out  1  valid entry with matching tag.
- `update_valid_in`  in  1  resolved branch/jump present this cycle.
- `update_pc_in`  in  64  PC of resolved instruction.
- `update_taken_in`  in  1  actual direction.
- `update_target_in`  in  64  actual taken target.

## Operation
- Entry state: `valid` (1), `tag` (TAG_BITS), `ctr` (2), `target` (64). Encoding of `ctr`:
  - 00 = strong not-taken
  - 01 = weak not-taken
  - 10 = weak taken
  - 11 = strong taken
- Lookup is combinational from stored state:
  - hit = `valid[idx] & (tag[idx] == pc tag)`.
  - `predicted_taken_out` = hit & `ctr[1]`.
  - `predicted_pc_out` = taken ? `{target[63:2], 2'b00}` : `pc_in + 4`, modulo 2^64.
- `pc_in[1:0]` and `update_pc_in[1:0]` are ignored for indexing and tagging.
- Update on edge when `update_valid_in`:
  - Hit, taken: `ctr` saturating increment (11 stays 11); `target` <= `update_target_in`.
  - Hit, not taken: `ctr` saturating decrement (00 stays 00); `target` unchanged.
  - Miss, taken: allocate, replacing any occupant. Set `valid`=1, `tag` from `update_pc_in`, `ctr`=10, `target` <= `update_target_in`.
  - Miss, not taken: no state change.
- Priority when events coincide: `reset` > `flush_in` > update.
  - Reset: all `valid`=0, all `ctr`=01, all `target`=0.
  - Flush: all `valid`=0; `ctr` and `target` retained but unreachable until reallocated.
  - An update in the same cycle as flush or reset is dropped.

## Timing
- Prediction latency 0 cycles: outputs follow `pc_in` and current state combinationally.
- Update visible to lookups starting the cycle after the update edge.
- No read-after-write bypass: a lookup to the entry being updated in the same cycle sees the pre-update value.
- One update accepted per cycle, with no backpressure. Consecutive-cycle updates to the same index each apply in order.
- Output values during and after reset, for any `pc_in`:
  - `hit_out`=0
  - `predicted_taken_out`=0
  - `predicted_pc_out`=`pc_in+4`
- `reset` asserted mid-training discards all history at that edge; the first post-reset update behaves as a miss.
- Wrap-around: `pc_in` = 0xFFFF_FFFF_FFFF_FFFC, not taken, gives `predicted_pc_out` = 0.

## Test plan
- **Reset:** reset 1 cycle, then `pc_in`=0x1000 → `hit_out`=0, `predicted_taken_out`=0, `predicted_pc_out`=0x1004.
- **Allocation:** update pc=0x1000, taken, target=0x2000. Next cycle `pc_in`=0x1000 → hit=1, taken=1, pc_out=0x2000. Then `pc_in`=0x1000+(1<<(INDEX_BITS+2)) → hit=0 (tag mismatch), pc_out=pc+4.
- **Hysteresis and saturation:**
  - From ctr=10: three taken updates → ctr=11 and stays 11.
  - Then one not-taken update → ctr=10, still predicts taken.
  - A second not-taken update → ctr=01, predicts not-taken, pc_out=0x1004.
  - Further not-taken updates saturate at 00.
- **Same-cycle read/write:** hold `pc_in`=0x1000 while updating 0x1000 taken on a miss → taken=0 that cycle, taken=1 the next.
- **Flush priority:** with a trained entry, assert `flush_in` and an update to another PC in the same cycle → next cycle both PCs report hit=0. Retrain 0x1000 with one taken update → ctr=10.
- **Wrap and alignment:** `pc_in`=0xFFFF_FFFF_FFFF_FFFC on a miss → pc_out=0. Allocate with target 0x3002 → pc_out=0x3000.
